// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command, ALU and response signals of the accumulator sequencer
//    cmd_*  : command handshake (valid/ready) with load flag, mode, operand B, carry-in, repeat count
//    alu_*  : operands/mode towards the combinational ALU and its result/overflow back
//    rsp_*  : result handshake (valid/ready) with accumulator and overflow
//    busy   : sequencer is not idle
//    slave  : the sequencer side; master: the command source / ALU / consumer side
interface alu_sequencer_if #(parameter int CNT_W = 4);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_load;
   logic [2:0]       cmd_mode;
   logic [3:0]       cmd_opb;
   logic             cmd_cin;
   logic [CNT_W-1:0] cmd_rep;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic             alu_cin;
   logic [2:0]       alu_mode;
   logic [3:0]       alu_r;
   logic             alu_ovf;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [3:0]       rsp_acc;
   logic             rsp_ovf;
   logic             busy;
   modport slave (
      input  cmd_valid, cmd_load, cmd_mode, cmd_opb, cmd_cin, cmd_rep, alu_r, alu_ovf, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_cin, alu_mode, rsp_valid, rsp_acc, rsp_ovf, busy
   );
   modport master (
      output cmd_valid, cmd_load, cmd_mode, cmd_opb, cmd_cin, cmd_rep, alu_r, alu_ovf, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_cin, alu_mode, rsp_valid, rsp_acc, rsp_ovf, busy
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one command at a time, loads the accumulator or applies an ALU op 1..2^CNT_W times
//    clk, rst_n : clock, asynchronous active-low reset
//    bus        : alu_sequencer_if slave (cmd_* in, alu_* out/in, rsp_* out, busy out)
//    ALU_SEQ_STICKY_OVF_EN adds ovf_sticky (out, set on any sampled overflow) and ovf_clr (in, sync clear)
module alu_sequencer #(parameter int CNT_W = 4) (
   input  logic clk,
   input  logic rst_n,
`ifdef ALU_SEQ_STICKY_OVF_EN
   input  logic ovf_clr,
   output logic ovf_sticky,
`endif
   alu_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           state_q;
   logic [3:0]       acc_q;
   logic [3:0]       opb_q;
   logic [2:0]       mode_q;
   logic             cin_q;
   logic             ovf_q;
   logic [CNT_W-1:0] cnt_q;
   logic             exec;
   logic             ovf_mode;
   assign exec     = state_q == EXEC;
   // only add/sub produce a meaningful overflow; other modes may float alu_ovf
   assign ovf_mode = mode_q[2:1] == 2'b00;
   // gated by rst_n so the command source sees not-ready for the whole reset
   assign bus.cmd_ready = rst_n && state_q == IDLE;
   assign bus.rsp_valid = state_q == RESP;
   assign bus.busy      = state_q != IDLE;
   assign bus.rsp_acc   = acc_q;
   assign bus.rsp_ovf   = ovf_q;
   assign bus.alu_a     = acc_q;
   assign bus.alu_b     = exec ? opb_q : 4'd0;
   assign bus.alu_cin   = exec ? cin_q : 1'b0;
   assign bus.alu_mode  = exec ? mode_q : 3'd0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= 4'd0;
         opb_q   <= 4'd0;
         mode_q  <= 3'd0;
         cin_q   <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.cmd_valid) begin
               mode_q  <= bus.cmd_mode;
               opb_q   <= bus.cmd_opb;
               cin_q   <= bus.cmd_cin;
               cnt_q   <= bus.cmd_rep;
               ovf_q   <= 1'b0;
               acc_q   <= bus.cmd_load ? bus.cmd_opb : acc_q;
               state_q <= bus.cmd_load ? RESP : EXEC;
            end
            EXEC: begin
               acc_q   <= bus.alu_r;
               ovf_q   <= ovf_mode ? (ovf_q | bus.alu_ovf) : ovf_q;
               // counting down to zero inclusive gives rep+1 iterations without needing a wider counter
               cnt_q   <= cnt_q - 1'b1;
               state_q <= cnt_q == '0 ? RESP : EXEC;
            end
            RESP: state_q <= bus.rsp_ready ? IDLE : RESP;
            default: state_q <= IDLE;
         endcase
      end
   end
`ifdef ALU_SEQ_STICKY_OVF_EN
   logic sticky_q;
   // a set in the same cycle as ovf_clr wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sticky_q <= 1'b0;
      else if (exec && ovf_mode && bus.alu_ovf) sticky_q <= 1'b1;
      else if (ovf_clr) sticky_q <= 1'b0;
   end
   assign ovf_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven check of alu_sequencer against a behavioural 4-bit ALU
module tb_alu_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   alu_sequencer_if #(.CNT_W(4)) bus ();
`ifdef ALU_SEQ_STICKY_OVF_EN
   logic ovf_clr = 1'b0;
   logic ovf_sticky;
   alu_sequencer #(.CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky), .bus(bus));
`else
   alu_sequencer #(.CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
   always #5 clk = ~clk;
   // ALU: signed overflow for add/sub; other modes drive junk 1 on alu_ovf, which must never be sampled
   logic [3:0] m_r;
   logic       m_ovf;
   always_comb begin
      m_r   = 4'd0;
      m_ovf = 1'b1;
      case (bus.alu_mode)
         3'd0: begin
            m_r   = bus.alu_a + bus.alu_b + {3'd0, bus.alu_cin};
            m_ovf = (bus.alu_a[3] == bus.alu_b[3]) && (m_r[3] != bus.alu_a[3]);
         end
         3'd1: begin
            m_r   = bus.alu_a - bus.alu_b;
            m_ovf = (bus.alu_a[3] != bus.alu_b[3]) && (m_r[3] != bus.alu_a[3]);
         end
         3'd2: m_r = {3'd0, bus.alu_a == bus.alu_b};
         3'd3: m_r = bus.alu_a & bus.alu_b;
         3'd4: m_r = bus.alu_a | bus.alu_b;
         3'd5: m_r = ~bus.alu_a;
         3'd6: m_r = bus.alu_a + 4'd1;
         default: m_r = bus.alu_a - 4'd1;
      endcase
   end
   assign bus.alu_r   = m_r;
   assign bus.alu_ovf = m_ovf;
   typedef struct {
      logic       load;
      logic [2:0] mode;
      logic [3:0] opb;
      logic       cin;
      logic [3:0] rep;
      logic [3:0] acc;
      logic       ovf;
   } vec_t;
   vec_t vecs[17];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // entered and left at a negedge with the DUT idle
   task automatic run_cmd(input vec_t v, input int idx);
      int n = 0;
      logic bad = 1'b0;
      bus.cmd_load  = v.load;
      bus.cmd_mode  = v.mode;
      bus.cmd_opb   = v.opb;
      bus.cmd_cin   = v.cin;
      bus.cmd_rep   = v.rep;
      bus.cmd_valid = 1'b1;
      chk($sformatf("v%0d cmd_ready", idx), 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      for (int g = 0; g < 40 && !bus.rsp_valid; g++) begin
         if (bus.busy) begin
            n++;
            if (bus.alu_b !== v.opb || bus.alu_mode !== v.mode || bus.alu_cin !== v.cin) bad = 1'b1;
         end
         @(negedge clk);
      end
      chk($sformatf("v%0d rsp_valid", idx), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("v%0d exec_cycles", idx), 32'(n), v.load ? 32'd0 : 32'(v.rep) + 32'd1);
      chk($sformatf("v%0d alu_drive", idx), 32'(bad), 32'd0);
      chk($sformatf("v%0d rsp_acc", idx), 32'(bus.rsp_acc), 32'(v.acc));
      chk($sformatf("v%0d rsp_ovf", idx), 32'(bus.rsp_ovf), 32'(v.ovf));
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk($sformatf("v%0d turnaround", idx), 32'({bus.rsp_valid, bus.cmd_ready}), 32'b01);
   endtask
   initial begin
      logic seen;
      vecs = '{
         '{1'b1, 3'd0, 4'h1, 1'b0, 4'd0,  4'h1, 1'b0},
         '{1'b0, 3'd0, 4'h2, 1'b0, 4'd2,  4'h7, 1'b0},
         '{1'b1, 3'd0, 4'h8, 1'b0, 4'd0,  4'h8, 1'b0},
         '{1'b0, 3'd0, 4'h8, 1'b0, 4'd0,  4'h0, 1'b1},
         '{1'b0, 3'd3, 4'hF, 1'b0, 4'd0,  4'h0, 1'b0},
         '{1'b0, 3'd6, 4'h0, 1'b0, 4'd15, 4'h0, 1'b0},
         '{1'b1, 3'd0, 4'h5, 1'b0, 4'd0,  4'h5, 1'b0},
         '{1'b0, 3'd1, 4'h3, 1'b0, 4'd1,  4'hF, 1'b0},
         '{1'b0, 3'd0, 4'h1, 1'b1, 4'd0,  4'h1, 1'b0},
         '{1'b1, 3'd0, 4'h7, 1'b0, 4'd0,  4'h7, 1'b0},
         '{1'b0, 3'd0, 4'h1, 1'b0, 4'd0,  4'h8, 1'b1},
         '{1'b0, 3'd4, 4'h3, 1'b0, 4'd0,  4'hB, 1'b0},
         '{1'b0, 3'd5, 4'h0, 1'b0, 4'd1,  4'hB, 1'b0},
         '{1'b0, 3'd7, 4'h0, 1'b0, 4'd2,  4'h8, 1'b0},
         '{1'b0, 3'd1, 4'h1, 1'b0, 4'd0,  4'h7, 1'b1},
         '{1'b0, 3'd2, 4'h7, 1'b0, 4'd0,  4'h1, 1'b0},
         '{1'b1, 3'd7, 4'h3, 1'b1, 4'd15, 4'h3, 1'b0}
      };
      bus.cmd_valid = 1'($urandom);
      bus.cmd_load  = 1'($urandom);
      bus.cmd_mode  = 3'($urandom);
      bus.cmd_opb   = 4'($urandom);
      bus.cmd_cin   = 1'($urandom);
      bus.cmd_rep   = 4'($urandom);
      bus.rsp_ready = 1'($urandom);
      repeat (3) @(negedge clk);
      chk("rst outputs", 32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_acc, bus.rsp_ovf, bus.busy}), 32'd0);
      chk("rst alu", 32'({bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_mode}), 32'd0);
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst release", 32'({bus.cmd_ready, bus.busy, bus.rsp_valid}), 32'b100);
      for (int i = 0; i < 17; i++) begin
         run_cmd(vecs[i], i);
`ifdef ALU_SEQ_STICKY_OVF_EN
         if (i == 3) chk("sticky set", 32'(ovf_sticky), 32'd1);
`endif
      end
      // backpressure: consumer stalls while a new command is offered
      bus.cmd_load  = 1'b1;
      bus.cmd_opb   = 4'h9;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_opb = 4'h2;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp hold %0d", i), 32'({bus.rsp_valid, bus.cmd_ready, bus.rsp_acc}), 32'({1'b1, 1'b0, 4'h9}));
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("bp release", 32'({bus.rsp_valid, bus.cmd_ready, bus.rsp_acc}), 32'({1'b0, 1'b1, 4'h9}));
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("bp next cmd", 32'({bus.rsp_valid, bus.rsp_acc}), 32'({1'b1, 4'h2}));
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      // reset during the second EXEC cycle of a 6-iteration add
      bus.cmd_load  = 1'b0;
      bus.cmd_mode  = 3'd0;
      bus.cmd_opb   = 4'h1;
      bus.cmd_cin   = 1'b0;
      bus.cmd_rep   = 4'd5;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("mid exec busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid rst outputs", 32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_acc, bus.rsp_ovf, bus.busy}), 32'd0);
      chk("mid rst alu", 32'({bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_mode}), 32'd0);
`ifdef ALU_SEQ_STICKY_OVF_EN
      chk("mid rst sticky", 32'(ovf_sticky), 32'd0);
`endif
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen |= bus.rsp_valid;
      end
      chk("mid rst no rsp", 32'(seen), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid rst release", 32'({bus.cmd_ready, bus.busy, bus.rsp_valid}), 32'b100);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven accumulator controller that sequences the team's 4-bit ALU. It accepts one command at a time over a valid/ready handshake and either loads the accumulator or applies one ALU operation 1..2^CNT_W times with the accumulator as operand A. It reports the result over a second valid/ready handshake. The block sits between a command source (test controller or bus decoder) and the combinational ALU, which it drives directly.

## Interface
- CNT_W, 4, width of repeat count; iterations per command = cmd_rep + 1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_load  in  1  1 = load accumulator with cmd_opb; no ALU operation
- cmd_mode  in  3  ALU mode: 0 add, 1 sub, 2 compare, 3 AND, 4 OR, 5 NOT A, 6 A+1, 7 A-1
- cmd_opb  in  4  operand B, or load value
- cmd_cin  in  1  carry-in for mode 0
- cmd_rep  in  CNT_W  repeat count minus one
- alu_a, alu_b  out  4  ALU operands
- alu_cin  out  1  ALU carry-in
- alu_mode  out  3  ALU mode select
- alu_r  in  4  ALU result, combinational from alu_* outputs
- alu_ovf  in  1  ALU overflow; valid only for modes 0/1, may be Z otherwise
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_acc  out  4  accumulator value
- rsp_ovf  out  1  overflow for the completed command
- busy  out  1  high in any state except IDLE

## Operation
- State machine with states IDLE, EXEC and RESP.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid, register mode, opb, cin and rep (cnt<=cmd_rep) and clear ovf_q.
  - If cmd_load=1: acc<=cmd_opb, go to RESP; cmd_mode, cmd_cin and cmd_rep are ignored.
  - Otherwise go to EXEC.
- **EXEC**
  - Drive alu_a=acc, alu_b=opb_q, alu_mode=mode_q, alu_cin=cin_q.
  - Each cycle: acc<=alu_r.
  - If mode_q is 0 or 1: ovf_q<=ovf_q|alu_ovf. For modes 2..7, alu_ovf is ignored and never sampled into state.
  - If cnt==0, go to RESP; else cnt<=cnt-1.
- **RESP**
  - rsp_valid=1; rsp_acc=acc and rsp_ovf=ovf_q are held stable.
  - When rsp_ready=1, go to IDLE.
- Outside EXEC, the ALU is driven with alu_a=acc, alu_b=0, alu_cin=0, alu_mode=0.
- rsp_acc always shows acc, but it is meaningful only while rsp_valid=1.
- The accumulator persists across commands.
- All arithmetic is 4-bit modulo 16, exactly as the ALU returns it; the block does no extra width extension.
- cmd_rep at its maximum (2^CNT_W-1) gives 2^CNT_W iterations, with no counter wrap issue.

## Timing
- Reset values: cmd_ready=0 while rst_n is low, 1 after release (IDLE). rsp_valid=0, rsp_acc=0, rsp_ovf=0, busy=0, alu_a=0, alu_b=0, alu_cin=0, alu_mode=0.
- Reset internals: acc=0, cnt=0, ovf_q=0.
- Load command: accepted at edge N, rsp_valid=1 from N+1.
- ALU command: EXEC occupies cycles N+1..N+1+cmd_rep; rsp_valid rises at edge N+2+cmd_rep.
- Minimum turnaround: a RESP handshake at edge M makes cmd_ready=1 from M+1. There is no same-cycle response-to-command overlap.
- cmd_valid while busy: ignored, and the command is not consumed.
- Once rsp_valid is asserted, rsp_acc and rsp_ovf must not change until the handshake completes.
- rst_n low in any state clears all state immediately. Any in-flight command and pending response are discarded.

## Configuration
- Macro: ALU_SEQ_STICKY_OVF_EN.
- **Defined:** adds two ports.
  - ovf_sticky  out  1: set when any EXEC cycle samples overflow (modes 0/1, alu_ovf=1); reset value 0.
  - ovf_clr  in  1: synchronous clear.
  - If a set and ovf_clr occur in the same cycle, the set wins.
- **Undefined:** both ports and the sticky register are absent. Remaining behaviour is identical.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release -> cmd_ready=1, busy=0.
- Load 1, then add (mode 0, opb 2, cin 0, rep 2) -> exactly 3 EXEC cycles, rsp_acc=7, rsp_ovf=0.
- Load 8, then add (opb 8, rep 0) -> rsp_acc=0, rsp_ovf=1. Then an AND (mode 3, opb F) with alu_ovf=Z -> rsp_ovf=0, no X propagates.
- From acc=0, increment (mode 6, rep 15) -> 16 EXEC cycles with busy=1, rsp_acc=0 after wrap, rsp_ovf=0.
- Backpressure: hold rsp_ready=0 for 3 cycles while offering cmd_valid -> rsp_valid/rsp_acc held, cmd_ready=0, new command not consumed. Accepted in the cycle after rsp_ready.
- Reset mid-EXEC (rep 5, rst_n low at the 2nd EXEC cycle) -> immediate return to reset values, no rsp_valid pulse. With ALU_SEQ_STICKY_OVF_EN, ovf_sticky=0.
